data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 14 +
 rtl/store_buffer.sv | 70 +++++++
 rtl/data_memory.sv | 80 ++++++++
 tb/tb_data_memory.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared widths, default sizes and the store-buffer entry layout for data_memory.
package data_memory_pkg;
  localparam int DATA_W           = 32;
  localparam int DEFAULT_DEPTH    = 256;
  localparam int DEFAULT_SB_DEPTH = 4;
  // Widest word index a 32-bit byte address can carry; narrower arrays zero-extend.
  localparam int IDX_MAX_W        = 30;

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] index;
    logic [DATA_W-1:0]    data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer.sv
// Circular store FIFO with a youngest-match lookup so loads see buffered stores.
module store_buffer
  import data_memory_pkg::*;
#(
  parameter int SB_DEPTH = DEFAULT_SB_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [IDX_MAX_W-1:0] push_index,
  input  logic [DATA_W-1:0]    push_data,
  input  logic                 pop,
  input  logic [IDX_MAX_W-1:0] lookup_index,
  output logic                 hit,
  output logic [DATA_W-1:0]    hit_data,
  output sb_entry_t            head_entry,
  output logic                 full,
  output logic                 empty
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  sb_entry_t        entries [SB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] slot;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == CNT_W'(SB_DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_entry = entries[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (do_push) begin
        entries[tail] <= '{valid: 1'b1, index: push_index, data: push_data};
        tail          <= tail + 1'b1;
      end
      if (do_pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Scan oldest to youngest so the last match (the youngest store) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (entries[slot].valid && (entries[slot].index == lookup_index)) begin
        hit      = 1'b1;
        hit_data = entries[slot].data;
      end
    end
  end
endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory fronted by a store buffer; loads forward buffered stores.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int SB_DEPTH = DEFAULT_SB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_datamem_ce,
  input  logic              mem_datamem_wrn,
  input  logic [31:0]       mem_datamem_addr,
  input  logic [DATA_W-1:0] mem_datamem_wrdata,
  output logic [DATA_W-1:0] datamem_mem_redata,
  output logic              mem_stall_req,
  output logic              sb_empty,
  output logic              align_err
);
  localparam int IDX_W = $clog2(DEPTH);

  // Handshake: a request is valid when ce=1; a store is accepted at the edge only
  // when mem_stall_req=0 that cycle, otherwise the requester must hold and retry.
  // Loads never stall and return data combinationally in the request cycle.

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              is_load;
  logic              is_store;
  logic              sb_push;
  logic              sb_pop;
  logic              sb_hit;
  logic              sb_full;
  logic              sb_is_empty;
  logic [DATA_W-1:0] sb_hit_data;
  sb_entry_t         sb_head;
  logic              unused_bits;

  assign idx      = mem_datamem_addr[IDX_W+1:2];
  assign is_load  = mem_datamem_ce && !mem_datamem_wrn;
  assign is_store = mem_datamem_ce && mem_datamem_wrn;

  assign mem_stall_req = is_store && sb_full;
  assign sb_push       = is_store && !sb_full;
  // The array port is free only when no access uses it or a store is stalling.
  assign sb_pop        = !sb_is_empty && (!mem_datamem_ce || mem_stall_req);
  assign sb_empty      = sb_is_empty;

  assign unused_bits = ^{mem_datamem_addr[31:IDX_W+2], sb_head.valid,
                         sb_head.index[IDX_MAX_W-1:IDX_W]};

  store_buffer #(.SB_DEPTH(SB_DEPTH)) u_store_buffer (
    .clk          (clk),
    .reset        (reset),
    .push         (sb_push),
    .push_index   (IDX_MAX_W'(idx)),
    .push_data    (mem_datamem_wrdata),
    .pop          (sb_pop),
    .lookup_index (IDX_MAX_W'(idx)),
    .hit          (sb_hit),
    .hit_data     (sb_hit_data),
    .head_entry   (sb_head),
    .full         (sb_full),
    .empty        (sb_is_empty)
  );

  always_comb begin
    datamem_mem_redata = '0;
    if (is_load) datamem_mem_redata = sb_hit ? sb_hit_data : mem[idx];
  end

  // Array contents survive reset; only the buffer and the flag are cleared.
  always_ff @(posedge clk) begin
    if (sb_pop) mem[sb_head.index[IDX_W-1:0]] <= sb_head.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                  align_err <= 1'b0;
    else if (mem_datamem_ce && (mem_datamem_addr[1:0] != 2'b00)) align_err <= 1'b1;
  end
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: driver predicts from an architectural model, monitor compares.
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int SBD = 4;
  localparam int NW  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        wrn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wrdata = '0;
  logic [31:0] redata;
  logic        stall;
  logic        sb_empty;
  logic        align_err;

  always #5 clk = ~clk;

  data_memory #(.DEPTH(256), .SB_DEPTH(SBD)) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_datamem_ce     (ce),
    .mem_datamem_wrn    (wrn),
    .mem_datamem_addr   (addr),
    .mem_datamem_wrdata (wrdata),
    .datamem_mem_redata (redata),
    .mem_stall_req      (stall),
    .sb_empty           (sb_empty),
    .align_err          (align_err)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  stat_q[$];
  logic [31:0] arch_mem [256];
  logic [31:0] committed [256];
  pend_t       pend_q[$];
  bit          model_aerr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation record per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (stat_q.size() > 0) begin
      logic [2:0] s;
      s = stat_q.pop_front();
      check("stall", 32'(stall), 32'(s[2]));
      check("sb_empty", 32'(sb_empty), 32'(s[1]));
      check("align_err", 32'(align_err), 32'(s[0]));
      if (exp_q.size() > 0) check("redata", redata, exp_q.pop_front());
      else check("redata_queue", 32'd0, 32'd1);
    end
  end

  task automatic cycle(input bit c, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output bit stalled);
    int i;
    bit st;
    bit dr;
    i = int'(a[9:2]);
    ce = c; wrn = w; addr = a; wrdata = d;
    st = c && w && (pend_q.size() == SBD);
    dr = (pend_q.size() > 0) && (!c || st);
    exp_q.push_back((c && !w) ? arch_mem[i] : 32'h0);
    stat_q.push_back({st, pend_q.size() == 0, model_aerr});
    @(posedge clk);
    if (dr) begin
      committed[pend_q[0].idx] = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    if (c && w && !st) begin
      pend_q.push_back('{i, d});
      arch_mem[i] = d;
    end
    if (c && a[1:0] != 2'b00) model_aerr = 1'b1;
    #1;
    stalled = st;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bit s;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b1, a, d, s);
      if (!s) return;
    end
    check("store_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [31:0] a);
    bit s;
    cycle(1'b1, 1'b0, a, 32'h0, s);
  endtask

  task automatic idle(input int n);
    bit s;
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'h0, 32'h0, s);
  endtask

  // Reset asserted one cycle, starting mid-cycle; outputs must clear at once.
  task automatic do_reset();
    ce = 1'b0; wrn = 1'b0;
    reset = 1'b1;
    pend_q.delete();
    model_aerr = 1'b0;
    for (int k = 0; k < 256; k++) arch_mem[k] = committed[k];
    exp_q.push_back(32'h0);
    stat_q.push_back(3'b010);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    for (int w = 0; w < NW; w++) store(32'(w << 2), $urandom);
    idle(6);

    store(32'h10, 32'hDEADBEEF);
    load(32'h10);
    idle(4);

    store(32'h20, 32'h1);
    store(32'h20, 32'h2);
    load(32'h20);
    idle(2);
    load(32'h20);

    for (int k = 0; k < 5; k++) store(32'(k * 4), $urandom);
    idle(5);
    for (int k = 0; k < 5; k++) load(32'(k * 4));

    store(32'h30, 32'h1111_0000);
    store(32'h34, 32'h2222_0000);
    store(32'h38, 32'h3333_0000);
    do_reset();
    load(32'h30);
    load(32'h34);
    load(32'h38);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, NW - 1) << 2);
      case ($urandom_range(0, 2))
        0:       idle(1);
        1:       load(a);
        default: store(a, $urandom);
      endcase
    end
    idle(6);

    store(32'h13, 32'hA5A5A5A5);
    load(32'h10);
    idle(6);
    load(32'h10);
    do_reset();
    idle(1);
    load(32'h10);

    if (exp_q.size() != 0 || stat_q.size() != 0) check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
